// File: rtl/roulette_payout_engine.sv
// Roulette settlement engine: latches a spin and up to twelve bet words, scores one
// bet per cycle, then applies the net result to a saturating player balance.
`default_nettype none

module roulette_payout_engine #(
    parameter logic [15:0] START_BALANCE = 16'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  led_number,
    input  logic [5:0]  bet_count,
    input  logic [95:0] bets,
    output logic        busy,
    output logic        done,
    output logic [11:0] wager,
    output logic [15:0] payout,
    output logic [11:0] win_mask,
    output logic        bad_result,
    output logic [15:0] balance
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Bit n set when pocket n is red
    localparam logic [36:0] RED_MASK = 37'h1_54AA_D52AA;

    state_t       state_q;
    logic [5:0]   pocket_q;
    logic [95:0]  bets_q;
    logic [3:0]   count_q;
    logic [3:0]   index_q;
    logic         busy_q;
    logic         done_q;
    logic [11:0]  wager_q;
    logic [15:0]  payout_q;
    logic [11:0]  win_mask_q;
    logic         bad_q;
    logic [15:0]  balance_q;

    logic [3:0]   count_d;
    logic [95:0]  bets_shift;
    logic [7:0]   word_d;
    logic [5:0]   op_d;
    logic [4:0]   stake_d;
    logic [5:0]   mult_d;
    logic         skip_d;
    logic         red_d;
    logic [5:0]   col_d;
    logic signed [17:0] bal_sum_d;
    logic [15:0]  balance_d;

    assign count_d = (bet_count > 6'd12) ? 4'd12 : bet_count[3:0];

    always_comb begin
        bets_shift = bets_q >> {index_q, 3'b000};
        word_d     = bets_shift[7:0];
        op_d       = word_d[5:0];
        skip_d     = (op_d >= 6'd62);
        red_d      = (pocket_q <= 6'd36) && RED_MASK[pocket_q];
        col_d      = pocket_q % 6'd3;
        case (word_d[7:6])
            2'b00:   stake_d = 5'd1;
            2'b01:   stake_d = 5'd5;
            2'b10:   stake_d = 5'd10;
            default: stake_d = 5'd25;
        endcase
        // mult_d is the return multiplier when the bet wins, zero when it loses
        mult_d = 6'd0;
        if (op_d <= 6'd36) begin
            if (pocket_q == op_d) mult_d = 6'd36;
        end else if (pocket_q != 6'd0 && pocket_q <= 6'd36) begin
            case (op_d)
                6'd37: if (red_d)                       mult_d = 6'd2;
                6'd38: if (!red_d)                      mult_d = 6'd2;
                6'd39: if (pocket_q[0])                 mult_d = 6'd2;
                6'd40: if (!pocket_q[0])                mult_d = 6'd2;
                6'd41: if (pocket_q <= 6'd18)           mult_d = 6'd2;
                6'd42: if (pocket_q >= 6'd19)           mult_d = 6'd2;
                6'd43: if (pocket_q <= 6'd12)           mult_d = 6'd3;
                6'd44: if (pocket_q >= 6'd13 && pocket_q <= 6'd24) mult_d = 6'd3;
                6'd45: if (pocket_q >= 6'd25)           mult_d = 6'd3;
                6'd46: if (col_d == 6'd1)               mult_d = 6'd3;
                6'd47: if (col_d == 6'd2)               mult_d = 6'd3;
                6'd48: if (col_d == 6'd0)               mult_d = 6'd3;
                default: mult_d = 6'd0;
            endcase
        end
    end

    always_comb begin
        bal_sum_d = $signed({2'b00, balance_q}) - $signed({6'b000000, wager_q})
                  + $signed({2'b00, payout_q});
        if (bal_sum_d < 0)
            balance_d = 16'd0;
        else if (bal_sum_d > 18'sd65535)
            balance_d = 16'hFFFF;
        else
            balance_d = bal_sum_d[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pocket_q   <= 6'd0;
            bets_q     <= 96'd0;
            count_q    <= 4'd0;
            index_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wager_q    <= 12'd0;
            payout_q   <= 16'd0;
            win_mask_q <= 12'd0;
            bad_q      <= 1'b0;
            balance_q  <= START_BALANCE;
        end else begin
            done_q <= 1'b0;
            if (done_q) busy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pocket_q   <= led_number;
                        bets_q     <= bets;
                        count_q    <= count_d;
                        index_q    <= 4'd0;
                        wager_q    <= 12'd0;
                        payout_q   <= 16'd0;
                        win_mask_q <= 12'd0;
                        bad_q      <= (led_number > 6'd36);
                        busy_q     <= 1'b1;
                        state_q    <= (count_d == 4'd0) ? S_UPDATE : S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (!skip_d) wager_q <= wager_q + 12'(stake_d);
                    if (!skip_d && !bad_q && mult_d != 6'd0) begin
                        payout_q            <= payout_q + 16'(stake_d) * 16'(mult_d);
                        win_mask_q[index_q] <= 1'b1;
                    end
                    index_q <= index_q + 4'd1;
                    if (index_q == count_q - 4'd1) state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (!bad_q) balance_q <= balance_d;
                    state_q <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign wager      = wager_q;
    assign payout     = payout_q;
    assign win_mask   = win_mask_q;
    assign bad_result = bad_q;
    assign balance    = balance_q;

endmodule

`default_nettype wire

// File: tb/tb_roulette_payout_engine.sv
// Randomized and directed bench for roulette_payout_engine against a table-driven model.
`default_nettype none

module tb_roulette_payout_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [5:0]  led_number;
    logic [5:0]  bet_count;
    logic [95:0] bets;

    logic        busy, done, bad_result;
    logic [11:0] wager, win_mask;
    logic [15:0] payout, balance;
    logic        busy2, done2, bad_result2;
    logic [11:0] wager2, win_mask2;
    logic [15:0] payout2, balance2;

    int total = 0;
    int bad   = 0;
    int model_bal;
    int model_bal2;

    roulette_payout_engine dut (
        .clock(clock), .reset(reset), .start(start), .led_number(led_number),
        .bet_count(bet_count), .bets(bets), .busy(busy), .done(done), .wager(wager),
        .payout(payout), .win_mask(win_mask), .bad_result(bad_result), .balance(balance)
    );

    roulette_payout_engine #(.START_BALANCE(16'd10)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .led_number(led_number),
        .bet_count(bet_count), .bets(bets), .busy(busy2), .done(done2), .wager(wager2),
        .payout(payout2), .win_mask(win_mask2), .bad_result(bad_result2), .balance(balance2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int chip_value(input int chip);
        case (chip)
            0:       return 1;
            1:       return 5;
            2:       return 10;
            default: return 25;
        endcase
    endfunction

    function automatic bit is_red(input int p);
        int reds[18] = '{1, 3, 5, 7, 9, 12, 14, 16, 18, 19, 21, 23, 25, 27, 30, 32, 34, 36};
        foreach (reds[i]) if (reds[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Return multiplier for a winning bet, 0 for a losing one
    function automatic int win_mult(input int op, input int p);
        if (p > 36) return 0;
        if (op <= 36) return (p == op) ? 36 : 0;
        if (op > 48 || p == 0) return 0;
        if (op == 37) return is_red(p) ? 2 : 0;
        if (op == 38) return is_red(p) ? 0 : 2;
        if (op == 39) return (p % 2 == 1) ? 2 : 0;
        if (op == 40) return (p % 2 == 0) ? 2 : 0;
        if (op == 41) return (p <= 18) ? 2 : 0;
        if (op == 42) return (p >= 19) ? 2 : 0;
        if (op <= 45) return ((p - 1) / 12 == op - 43) ? 3 : 0;
        return (p % 3 == (op - 45) % 3) ? 3 : 0;
    endfunction

    task automatic run(input bit use2, input int pocket, input int n,
                       input logic [95:0] b, input bit poke, input string tag);
        int nn, w, p, m, nb, e, op, chip, mult;
        bit busy_ok;
        logic [7:0] word;
        nn = (n > 12) ? 12 : n;
        w = 0; p = 0; m = 0;
        for (int i = 0; i < nn; i++) begin
            word = b[i*8 +: 8];
            op   = int'(word[5:0]);
            chip = int'(word[7:6]);
            if (op >= 62) continue;
            w += chip_value(chip);
            mult = win_mult(op, pocket);
            if (mult > 0) begin
                p += chip_value(chip) * mult;
                m |= (1 << i);
            end
        end
        nb = use2 ? model_bal2 : model_bal;
        if (pocket <= 36) begin
            nb = nb - w + p;
            if (nb < 0) nb = 0;
            if (nb > 65535) nb = 65535;
        end

        @(negedge clock);
        led_number = pocket[5:0];
        bet_count  = n[5:0];
        bets       = b;
        if (use2) start2 = 1'b1; else start = 1'b1;
        @(negedge clock);
        start = 1'b0; start2 = 1'b0;
        led_number = 6'($urandom_range(0, 36));
        bet_count  = 6'($urandom_range(0, 12));
        bets       = {$urandom, $urandom, $urandom};
        check({tag, ".busy_rise"}, int'(use2 ? busy2 : busy), 1);

        e = 0; busy_ok = 1'b1;
        while (!(use2 ? done2 : done) && e < 40) begin
            if (use2) start2 = poke && (e == 1); else start = poke && (e == 1);
            @(negedge clock);
            e++;
            if (!(use2 ? busy2 : busy)) busy_ok = 1'b0;
        end
        start = 1'b0; start2 = 1'b0;
        check({tag, ".latency"}, e, nn + 2);
        check({tag, ".busy_held"}, int'(busy_ok), 1);
        check({tag, ".wager"}, int'(use2 ? wager2 : wager), w);
        check({tag, ".payout"}, int'(use2 ? payout2 : payout), p);
        check({tag, ".win_mask"}, int'(use2 ? win_mask2 : win_mask), m);
        check({tag, ".bad_result"}, int'(use2 ? bad_result2 : bad_result), (pocket > 36) ? 1 : 0);
        check({tag, ".balance"}, int'(use2 ? balance2 : balance), nb);
        if (use2) model_bal2 = nb; else model_bal = nb;
        @(negedge clock);
        check({tag, ".done_pulse"}, int'(use2 ? done2 : done), 0);
        check({tag, ".busy_fall"}, int'(use2 ? busy2 : busy), 0);
    endtask

    initial begin
        logic [95:0] b;
        int done_seen;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        led_number = 6'd0; bet_count = 6'd0; bets = 96'd0;
        model_bal = 1000; model_bal2 = 10;
        repeat (2) @(negedge clock);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.wager", int'(wager), 0);
        check("rst.payout", int'(payout), 0);
        check("rst.win_mask", int'(win_mask), 0);
        check("rst.bad_result", int'(bad_result), 0);
        check("rst.balance", int'(balance), 1000);
        check("rst.balance2", int'(balance2), 10);
        reset = 1'b0;

        b = 96'd0; b[7:0] = 8'h51;
        run(1'b0, 17, 1, b, 1'b0, "straight17");
        check("straight17.abs_balance", int'(balance), 1175);

        b = 96'd0; b[7:0] = 8'hA5; b[15:8] = 8'hA8; b[23:16] = 8'h00;
        run(1'b0, 0, 3, b, 1'b0, "zero");

        b = {12{8'hF0}};
        run(1'b0, 36, 12, b, 1'b0, "col3");

        b = 96'd0; b[7:0] = 8'hE5; b[15:8] = 8'hF7;
        run(1'b1, 2, 2, b, 1'b0, "clamp");
        check("clamp.abs_balance", int'(balance2), 0);

        b = {$urandom, $urandom, $urandom};
        run(1'b0, 40, 2, b, 1'b1, "badpocket");

        run(1'b0, 5, 0, b, 1'b1, "nobets");

        for (int t = 0; t < 40; t++) begin
            b = {$urandom, $urandom, $urandom};
            run(t[0], $urandom_range(0, 40), $urandom_range(0, 15), b,
                t[2], $sformatf("rand%0d", t));
        end

        // Reset in the middle of an evaluation pass
        @(negedge clock);
        led_number = 6'd7; bet_count = 6'd12; bets = {12{8'h07}}; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.wager", int'(wager), 0);
        check("midrst.balance", int'(balance), 1000);
        check("midrst.balance2", int'(balance2), 10);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done || busy) done_seen++;
        end
        check("midrst.no_done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
